// File: rtl/l4q4_mem.sv
// l4q4_mem: 16-word scratch memory behind a shared tri-state data bus.
// The master writes through op while en is high; with en low the memory
// drives op with the addressed word, combinationally.
module l4q4_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] op,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr
);

  // Storage array, all flops so a reset leaves no unknown words behind.
  logic [DATA_W-1:0] mem [DEPTH];

  // Word currently addressed, presented on the bus during reads.
  logic [DATA_W-1:0] rdata;

  // Reset wipes every word and wins over a write in the same cycle;
  // otherwise en high captures the bus into the addressed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (en) begin
      mem[addr] <= op;
    end
  end

  // Combinational read path, so op follows addr within the cycle.
  always_comb begin
    rdata = mem[addr];
  end

  // Drive the bus only while the master has released it (en low);
  // reset does not affect direction.
  assign op = en ? {DATA_W{1'bz}} : rdata;

endmodule

// File: tb/tb_l4q4_mem.sv
// tb_l4q4_mem: directed and randomized checks of l4q4_mem against a
// word-array reference model kept in the bench.
module tb_l4q4_mem;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  addr;
  logic [15:0] drv;
  logic        drvEn;
  wire  [15:0] op;

  logic [15:0] model [16];
  int          testsRun;
  int          testsFailed;

  // Master side of the shared bus.
  assign op = drvEn ? drv : 16'hzzzz;

  l4q4_mem #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .op   (op),
    .en   (en),
    .addr (addr)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge with the given controls; the model applies the
  // memory rules (reset clears all and beats write; else write if en).
  task automatic applyStimulus(input logic r, input logic e, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    rst   = r;
    en    = e;
    addr  = a;
    drv   = d;
    drvEn = e;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    end else if (e) begin
      model[a] = d;
    end
    #1;
    rst   = 1'b0;
    en    = 1'b0;
    drvEn = 1'b0;
  endtask

  task automatic readCheck(input logic [3:0] a, input string tag);
    en    = 1'b0;
    drvEn = 1'b0;
    addr  = a;
    #1;
    checkOutput(tag, op, model[a]);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b0;
    en    = 1'b0;
    addr  = 4'd0;
    drv   = 16'h0000;
    drvEn = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    // Reset then sweep: every word reads zero.
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      readCheck(4'(i), "reset_sweep");
      checkOutput("reset_zero", op, 16'h0000);
    end

    // Write k to addr k for k=1..15, then read everything back.
    for (int k = 1; k < 16; k++) applyStimulus(1'b0, 1'b1, 4'(k), 16'(k));
    for (int i = 0; i < 16; i++) begin
      readCheck(4'(i), "seq_readback");
      checkOutput("seq_value", op, 16'(i));
    end

    // Bus direction: with en high the block stays off the bus.
    @(negedge clk);
    en    = 1'b1;
    addr  = 4'd5;
    drv   = 16'hA5A5;
    drvEn = 1'b1;
    #1;
    checkOutput("bus_master_drive", op, 16'hA5A5);
    en    = 1'b0;
    drvEn = 1'b0;
    #1;
    checkOutput("bus_block_drive", op, 16'h0005);

    // Overwrite addr 7; neighbours untouched.
    applyStimulus(1'b0, 1'b1, 4'd7, 16'h1234);
    applyStimulus(1'b0, 1'b1, 4'd7, 16'hFFFF);
    readCheck(4'd7, "overwrite_7");
    checkOutput("overwrite_val", op, 16'hFFFF);
    readCheck(4'd6, "overwrite_6");
    checkOutput("overwrite_n6", op, 16'h0006);
    readCheck(4'd8, "overwrite_8");
    checkOutput("overwrite_n8", op, 16'h0008);

    // Reset beats a simultaneous write.
    applyStimulus(1'b0, 1'b1, 4'd3, 16'h00FF);
    readCheck(4'd3, "prio_pre");
    applyStimulus(1'b1, 1'b1, 4'd3, 16'hBEEF);
    readCheck(4'd3, "prio_addr3");
    checkOutput("prio_zero", op, 16'h0000);
    readCheck(4'd7, "prio_addr7");

    // Combinational read: addr change between edges shows up at once.
    applyStimulus(1'b0, 1'b1, 4'd2, 16'h2222);
    applyStimulus(1'b0, 1'b1, 4'd9, 16'h9999);
    @(negedge clk);
    readCheck(4'd2, "comb_addr2");
    #2;
    readCheck(4'd9, "comb_addr9");
    checkOutput("comb_val9", op, 16'h9999);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic r;
      logic e;
      r = ($urandom_range(0, 39) == 0);
      e = $urandom_range(0, 1);
      applyStimulus(r, e, 4'($urandom_range(0, 15)), 16'($urandom));
      readCheck(4'($urandom_range(0, 15)), "rand_read");
    end
    for (int i = 0; i < 16; i++) readCheck(4'(i), "final_sweep");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
